// File: rtl/dcache_main_mem_if.sv
// Cache <-> main-memory line request/response bus.
interface dcache_main_mem_if #(
    parameter int LINE_W   = 256,
    parameter int ADDR_LEN = 10
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_LEN-1:0] req_addr;
    logic [LINE_W-1:0]   req_wdata;
    logic                resp_valid;
    logic [LINE_W-1:0]   resp_rdata;
    logic                busy;

    // Cache side: issues requests, observes completion.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy
    );

    // Memory side: serves one request at a time.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy
    );
endinterface

// File: rtl/dcache_main_mem.sv
// Line-granular main memory behind the data cache: one outstanding request,
// fixed access latency, per-type request counters.
module dcache_main_mem #(
    parameter int LINE_WORDS_LOG = 3,
    parameter int ADDR_LEN       = 10,
    parameter int LATENCY        = 50
) (
    input  logic             clk,
    input  logic             rst,
    dcache_main_mem_if.slave bus,
    output logic [31:0]      o_rd_req_count,
    output logic [31:0]      o_wr_req_count
);
    localparam int LINE_W = 32 << LINE_WORDS_LOG;
    localparam int DEPTH  = 1 << ADDR_LEN;
    localparam int CNT_W  = 10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [ADDR_LEN-1:0] r_addr;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_rdata;
    logic [31:0]         r_rd_cnt;
    logic [31:0]         r_wr_cnt;
    logic                w_accept;
    logic                w_complete;
    logic                w_ready;
    logic                w_busy;
    logic                w_resp;

    // Contents are configuration-initialised to zero and never touched by reset.
    logic [LINE_W-1:0]   r_mem [DEPTH] = '{default: '0};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next state and handshake outputs, all decoded from the current state.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_resp       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (r_cnt == '0) begin
                    w_complete   = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_busy       = 1'b1;
                w_resp       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request latch, countdown and statistics; inputs are ignored once accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_accept) begin
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            if (bus.req_we) r_wr_cnt <= r_wr_cnt + 32'd1;
            else            r_rd_cnt <= r_rd_cnt + 32'd1;
        end else if (r_state == S_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Write-back commits only on the completion edge, so a reset mid-flight drops it.
    always_ff @(posedge clk) begin
        if (w_complete && r_we) r_mem[r_addr] <= r_wdata;
    end

    // Refill data register; holds the last read line across later writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_rdata <= '0;
        else if (w_complete && !r_we) r_rdata <= r_mem[r_addr];
    end

    assign bus.req_ready   = w_ready;
    assign bus.busy        = w_busy;
    assign bus.resp_valid  = w_resp;
    assign bus.resp_rdata  = r_rdata;
    assign o_rd_req_count  = r_rd_cnt;
    assign o_wr_req_count  = r_wr_cnt;
endmodule

// File: tb/tb_dcache_main_mem.sv
// Directed bench: LATENCY=50 instance for the main checks, LATENCY=1 instance
// for the minimum-latency and top-address round trip.
module tb_dcache_main_mem;
    localparam int LW = 256;
    localparam int AL = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] rd0, wr0, rd1, wr1;
    int n_tests = 0;
    int n_fail  = 0;

    dcache_main_mem_if #(.LINE_W(LW), .ADDR_LEN(AL)) bus0 ();
    dcache_main_mem_if #(.LINE_W(LW), .ADDR_LEN(AL)) bus1 ();

    dcache_main_mem #(.LINE_WORDS_LOG(3), .ADDR_LEN(AL), .LATENCY(50)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .o_rd_req_count(rd0), .o_wr_req_count(wr0));
    dcache_main_mem #(.LINE_WORDS_LOG(3), .ADDR_LEN(AL), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .o_rd_req_count(rd1), .o_wr_req_count(wr1));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit d1, input bit v, input bit we, input logic [AL-1:0] a,
                         input logic [LW-1:0] wd);
        if (d1) begin
            bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = a; bus1.req_wdata = wd;
        end else begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = wd;
        end
    endtask

    // One request from idle; k counts cycles after the accept edge (k=0 is cycle N).
    task automatic xfer(input bit d1, input bit we, input logic [AL-1:0] a,
                        input logic [LW-1:0] wd, input int budget,
                        output int lat, output int np, output int nbusy,
                        output logic [LW-1:0] rd);
        lat = -1; np = 0; nbusy = 0; rd = '0;
        chk("ready_before_req", d1 ? bus1.req_ready : bus0.req_ready, 1);
        drive(d1, 1'b1, we, a, wd);
        tick();
        drive(d1, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k <= budget; k++) begin
            if (k > 0) tick();
            if (d1 ? bus1.resp_valid : bus0.resp_valid) begin
                if (lat < 0) lat = k;
                np++;
                rd = d1 ? bus1.resp_rdata : bus0.resp_rdata;
            end
            if (d1 ? bus1.busy : bus0.busy) nbusy++;
        end
    endtask

    logic [LW-1:0] L5, L6, L7, L8, LDEAD, LMAX, rd;
    int lat, np, nb, acc_n, cyc;
    int acc_at [3];
    logic pre_ready;

    initial begin
        for (int i = 0; i < 8; i++) begin
            L5[i*32 +: 32] = 32'h11 * (i + 1);
            L6[i*32 +: 32] = 32'hA000_0000 + i;
            LMAX[i*32 +: 32] = 32'hCAFE_0000 + i;
        end
        L7    = {8{32'h7777_0007}};
        L8    = {8{32'h0808_0808}};
        LDEAD = {8{32'hDEAD_BEEF}};
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        // Reset state
        tick(); tick();
        chk("rst_ready", bus0.req_ready, 1);
        chk("rst_resp_valid", bus0.resp_valid, 0);
        chk("rst_busy", bus0.busy, 0);
        chk("rst_rdata", bus0.resp_rdata, 0);
        chk("rst_rd_cnt", rd0, 0);
        chk("rst_wr_cnt", wr0, 0);
        rst = 1'b0;
        tick();

        // 1: write addr 5, latency 50
        xfer(1'b0, 1'b1, 10'd5, L5, 60, lat, np, nb, rd);
        chk("t1_latency", lat, 50);
        chk("t1_pulses", np, 1);
        chk("t1_busy_cycles", nb, 51);
        chk("t1_wr_cnt", wr0, 1);
        chk("t1_rd_cnt", rd0, 0);
        chk("t1_idle_ready", bus0.req_ready, 1);

        // 2: read back addr 5, then write addr 6 must not disturb resp_rdata
        xfer(1'b0, 1'b0, 10'd5, '0, 60, lat, np, nb, rd);
        chk("t2_latency", lat, 50);
        chk("t2_word0", rd[31:0], 32'h11);
        chk("t2_word7", rd[255:224], 32'h88);
        chk("t2_line", rd, L5);
        xfer(1'b0, 1'b1, 10'd6, L6, 60, lat, np, nb, rd);
        chk("t2_rdata_hold", bus0.resp_rdata, L5);
        chk("t2_rd_cnt", rd0, 1);
        chk("t2_wr_cnt", wr0, 2);

        // 3: valid held, we alternating R,W,R -> one accept per LATENCY+2 cycles
        acc_n = 0; cyc = 0;
        drive(1'b0, 1'b1, 1'b0, 10'd8, L8);
        while (acc_n < 3 && cyc < 400) begin
            pre_ready = bus0.req_ready;
            tick();
            cyc++;
            if (pre_ready) begin
                acc_at[acc_n] = cyc;
                acc_n++;
                bus0.req_we = ~bus0.req_we;
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk("t3_accepts", acc_n, 3);
        chk("t3_gap1", acc_at[1] - acc_at[0], 52);
        chk("t3_gap2", acc_at[2] - acc_at[1], 52);
        for (int k = 0; k < 60; k++) tick();
        chk("t3_rd_cnt", rd0, 3);
        chk("t3_wr_cnt", wr0, 3);

        // 4: valid pulses while busy are ignored
        drive(1'b0, 1'b1, 1'b0, 10'd5, '0);
        tick();
        lat = -1; np = 0; rd = '0;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) tick();
            drive(1'b0, (k >= 5 && k < 8), 1'b1, 10'd9, LDEAD);
            if (bus0.resp_valid) begin
                if (lat < 0) lat = k;
                np++;
                rd = bus0.resp_rdata;
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk("t4_latency", lat, 50);
        chk("t4_pulses", np, 1);
        chk("t4_rdata", rd, L5);
        chk("t4_rd_cnt", rd0, 4);
        chk("t4_wr_cnt", wr0, 3);

        // 5: aborted write to addr 7 leaves previous contents
        xfer(1'b0, 1'b1, 10'd7, L7, 60, lat, np, nb, rd);
        chk("t5_pre_wr_cnt", wr0, 4);
        drive(1'b0, 1'b1, 1'b1, 10'd7, LDEAD);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 10; k++) tick();
        chk("t5_busy_before_rst", bus0.busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_ready", bus0.req_ready, 1);
        chk("t5_rst_busy", bus0.busy, 0);
        chk("t5_rst_resp_valid", bus0.resp_valid, 0);
        chk("t5_rst_rdata", bus0.resp_rdata, 0);
        chk("t5_rst_rd_cnt", rd0, 0);
        chk("t5_rst_wr_cnt", wr0, 0);
        tick();
        rst = 1'b0;
        np = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus0.resp_valid) np++;
        end
        chk("t5_no_resp", np, 0);
        xfer(1'b0, 1'b0, 10'd7, '0, 60, lat, np, nb, rd);
        chk("t5_addr7_kept", rd, L7);
        chk("t5_rd_cnt", rd0, 1);
        chk("t5_wr_cnt", wr0, 0);

        // 6: LATENCY=1 instance, top address round trip
        xfer(1'b1, 1'b1, 10'd1023, LMAX, 8, lat, np, nb, rd);
        chk("t6_wr_latency", lat, 1);
        chk("t6_wr_pulses", np, 1);
        chk("t6_wr_busy_cycles", nb, 2);
        xfer(1'b1, 1'b0, 10'd1023, '0, 8, lat, np, nb, rd);
        chk("t6_rd_latency", lat, 1);
        chk("t6_rd_line", rd, LMAX);
        chk("t6_rd_cnt", rd1, 1);
        chk("t6_wr_cnt", wr1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
